// File: rtl/linebuffer_pp.sv
// Ping-pong sprite line buffer: the renderer fills the write bank while video reads and clears the other bank.
// Latency: RD_DATA/RD_VALID appear 1 cycle after RD_CE; pixel writes land on the next edge.
// Backpressure: none; all strobes are accepted every RUN cycle, and all inputs are ignored while BUSY.
module linebuffer_pp #(
    parameter int ADDR_W = 9,
    parameter int LINE_LEN = 320,
    parameter int PIX_W = 4,
    parameter int PAL_W = 8,
    parameter logic [PAL_W+PIX_W-1:0] CLEAR_VAL = '1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_swap,
    input  logic                     i_wr_load,
    input  logic [ADDR_W-1:0]        i_wr_addr_load,
    input  logic                     i_wr_dir,
    input  logic                     i_wr_pal_ce,
    input  logic [PAL_W-1:0]         i_wr_pal,
    input  logic                     i_wr_ce,
    input  logic [PIX_W-1:0]         i_wr_color,
    input  logic                     i_rd_start,
    input  logic                     i_rd_ce,
    output logic [PAL_W+PIX_W-1:0]   o_rd_data,
    output logic                     o_rd_valid,
    output logic                     o_bank,
    output logic                     o_busy
);
    localparam int D_W = PAL_W + PIX_W;
    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit so LINE_LEN == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LEN_C = (ADDR_W+1)'(LINE_LEN);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(LINE_LEN - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    logic                r_bank;
    logic                r_busy;
    logic [D_W-1:0]      r_rd_data;
    logic                r_rd_valid;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [PAL_W-1:0]    r_pal;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic [D_W-1:0]      r_mem [2][DEPTH];

    logic                w_run;
    logic                w_init_we;
    logic                w_pix_we;
    logic                w_rd_go;
    logic                w_rd_in;
    logic                w_clr_we;
    logic                w_rbank;
    logic [1:0]          w_we;
    logic [ADDR_W-1:0]   w_addr [2];
    logic [D_W-1:0]      w_wdat [2];

    assign w_run     = (r_state == ST_RUN) && !i_reset;
    assign w_init_we = (r_state == ST_INIT) && !i_reset;
    // Load wins over the pixel strobe; transparent and off-line pixels only move the pointer.
    assign w_pix_we  = w_run && !i_wr_load && i_wr_ce && (i_wr_color != '0)
                       && ({1'b0, r_wptr} < LEN_C);
    assign w_rd_in   = ({1'b0, r_rptr} < LEN_C);
    assign w_rd_go   = w_run && !i_rd_start && i_rd_ce;
    assign w_clr_we  = w_rd_go && w_rd_in;
    assign w_rbank   = ~r_bank;

    // Per-bank write-port mux: init sweep hits both banks, otherwise write bank takes pixels, read bank takes clears.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_we[b]   = 1'b0;
            w_addr[b] = '0;
            w_wdat[b] = CLEAR_VAL;
            if (w_init_we) begin
                w_we[b]   = 1'b1;
                w_addr[b] = r_init_cnt;
            end else if (r_bank == 1'(b)) begin
                w_we[b]   = w_pix_we;
                w_addr[b] = r_wptr;
                w_wdat[b] = {r_pal, i_wr_color};
            end else begin
                w_we[b]   = w_clr_we;
                w_addr[b] = r_rptr;
            end
        end
    end

    // Bank storage; the read of the read bank below sees the pre-clear value.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 2; b++) begin
            if (w_we[b]) begin
                r_mem[b][w_addr[b]] <= w_wdat[b];
            end
        end
    end

    // Control FSM plus write pointer, read pointer, palette and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_INIT;
            r_bank     <= 1'b0;
            r_busy     <= 1'b1;
            r_rd_data  <= CLEAR_VAL;
            r_rd_valid <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_pal      <= '0;
            r_init_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_busy     <= 1'b1;
                    r_rd_valid <= 1'b0;
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == LAST_C) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                    if (i_wr_pal_ce) begin
                        r_pal <= i_wr_pal;
                    end
                    if (i_wr_load) begin
                        r_wptr <= i_wr_addr_load;
                    end else if (i_wr_ce) begin
                        r_wptr <= i_wr_dir ? r_wptr - 1'b1 : r_wptr + 1'b1;
                    end
                    r_rd_valid <= w_rd_go;
                    if (i_rd_start) begin
                        r_rptr <= '0;
                    end else if (i_rd_ce) begin
                        if (w_rd_in) begin
                            r_rd_data <= r_mem[w_rbank][r_rptr];
                            r_rptr    <= r_rptr + 1'b1;
                        end else begin
                            r_rd_data <= CLEAR_VAL;
                        end
                    end
                    // Swap takes effect after this cycle's accesses, which used the old bank.
                    if (i_swap) begin
                        r_bank <= ~r_bank;
                        r_rptr <= '0;
                    end
                end
            endcase
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_bank     = r_bank;
    assign o_busy     = r_busy;
endmodule

// File: tb/tb_linebuffer_pp.sv
// Directed bench for linebuffer_pp with hand-computed expectations.
// Latency: reads checked 1 cycle after RD_CE; samples taken 1 time unit after the rising edge.
// Backpressure: none in the DUT; every bounded wait counts as a comparison.
module tb_linebuffer_pp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        swap = 1'b0;
    logic        wr_load = 1'b0;
    logic [8:0]  wr_addr_load = '0;
    logic        wr_dir = 1'b0;
    logic        wr_pal_ce = 1'b0;
    logic [7:0]  wr_pal = '0;
    logic        wr_ce = 1'b0;
    logic [3:0]  wr_color = '0;
    logic        rd_start = 1'b0;
    logic        rd_ce = 1'b0;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        bank;
    logic        busy;

    int n_vec = 0;
    int n_mis = 0;
    int rb [512];
    int rv [512];

    linebuffer_pp dut (
        .i_clk(clk), .i_reset(reset), .i_swap(swap),
        .i_wr_load(wr_load), .i_wr_addr_load(wr_addr_load), .i_wr_dir(wr_dir),
        .i_wr_pal_ce(wr_pal_ce), .i_wr_pal(wr_pal), .i_wr_ce(wr_ce), .i_wr_color(wr_color),
        .i_rd_start(rd_start), .i_rd_ce(rd_ce),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_bank(bank), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    task automatic load_ptr(input int a);
        wr_load = 1'b1;
        wr_addr_load = 9'(a);
        tick();
        wr_load = 1'b0;
    endtask

    task automatic pixel(input int c);
        wr_ce = 1'b1;
        wr_color = 4'(c);
        tick();
        wr_ce = 1'b0;
    endtask

    // RD_START, then n reads; rb[i]/rv[i] hold the result for read pointer i.
    task automatic read_n(input int n);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_ce = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            rb[i] = int'(rd_data);
            rv[i] = int'(rd_valid);
        end
        rd_ce = 1'b0;
    endtask

    // Counts cycles with BUSY high, starting from the current sample; also flags any RD_VALID.
    task automatic count_busy(output int cnt, output int anyv);
        cnt = 0;
        anyv = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            if (rd_valid) anyv = 1;
            tick();
        end
        if (rd_valid) anyv = 1;
    endtask

    initial begin
        int cnt;
        int anyv;
        int bad;

        // Reset state
        tick();
        tick();
        chk("rst_busy", int'(busy), 1);
        chk("rst_bank", int'(bank), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 'hFFF);

        // Init sweep with reads requested throughout
        reset = 1'b0;
        rd_ce = 1'b1;
        swap = 1'b1;
        count_busy(cnt, anyv);
        swap = 1'b0;
        chk("init_busy_len", cnt, 320);
        chk("init_no_valid", anyv, 0);
        chk("init_swap_ignored", int'(bank), 0);
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (rd_data !== 12'hFFF || rd_valid !== 1'b1) bad++;
        end
        rd_ce = 1'b0;
        chk("init_reads_bad", bad, 0);

        // Basic strip: pal 0x12, colours 3,0,5,7 at 10..13
        wr_pal_ce = 1'b1;
        wr_pal = 8'h12;
        tick();
        wr_pal_ce = 1'b0;
        load_ptr(10);
        pixel(3); pixel(0); pixel(5); pixel(7);
        do_swap();
        chk("swap_bank", int'(bank), 1);
        read_n(14);
        chk("strip_a10", rb[10], 'h123);
        chk("strip_a11", rb[11], 'hFFF);
        chk("strip_a12", rb[12], 'h125);
        chk("strip_a13", rb[13], 'h127);
        chk("strip_valid", rv[13], 1);
        do_swap();
        do_swap();
        read_n(14);
        chk("clr_a10", rb[10], 'hFFF);
        chk("clr_a12", rb[12], 'hFFF);
        chk("clr_a13", rb[13], 'hFFF);

        // Line end: 319 written, 320 dropped, read saturates
        load_ptr(319);
        pixel(1); pixel(2);
        do_swap();
        chk("end_bank", int'(bank), 0);
        read_n(322);
        chk("end_a318", rb[318], 'hFFF);
        chk("end_a319", rb[319], 'h121);
        chk("sat_data", rb[320], 'hFFF);
        chk("sat_valid", rv[320], 1);
        chk("sat_data2", rb[321], 'hFFF);
        chk("sat_valid2", rv[321], 1);

        // H-flip writes and pointer wrap below zero
        wr_dir = 1'b1;
        load_ptr(5);
        pixel(1); pixel(2); pixel(3);
        load_ptr(1);
        pixel(4); pixel(5); pixel(6);
        wr_dir = 1'b0;
        do_swap();
        read_n(6);
        chk("flip_a0", rb[0], 'h125);
        chk("flip_a1", rb[1], 'h124);
        chk("flip_a2", rb[2], 'hFFF);
        chk("flip_a3", rb[3], 'h123);
        chk("flip_a4", rb[4], 'h122);
        chk("flip_a5", rb[5], 'h121);

        // Load priority over pixel strobe; palette change uses old palette on that pixel
        load_ptr(20);
        wr_load = 1'b1;
        wr_addr_load = 9'd30;
        wr_ce = 1'b1;
        wr_color = 4'd9;
        tick();
        wr_load = 1'b0;
        wr_ce = 1'b0;
        wr_pal_ce = 1'b1;
        wr_pal = 8'h34;
        pixel(6);
        wr_pal_ce = 1'b0;
        pixel(7);
        do_swap();
        read_n(32);
        chk("load_pri_a20", rb[20], 'hFFF);
        chk("load_pri_a29", rb[29], 'hFFF);
        chk("pal_old_a30", rb[30], 'h126);
        chk("pal_new_a31", rb[31], 'h347);

        // Reset in the middle of the init sweep
        do_swap();
        chk("pre_rst_bank", int'(bank), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("mid_init_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rerst_bank", int'(bank), 0);
        rd_ce = 1'b1;
        count_busy(cnt, anyv);
        rd_ce = 1'b0;
        chk("rerst_busy_len", cnt, 320);
        chk("rerst_no_valid", anyv, 0);
        chk("rerst_bank_end", int'(bank), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/linebuffer_pp.md
Name: linebuffer_pp

Overview:
- Parametrised, double-buffered (ping-pong) sprite line buffer for the video pipeline, running on a single clock domain.
- Sprite renderer writes {palette, colour index} pixels into the write bank; the video output side reads the read bank and clears it behind itself to the backdrop value.
- Banks swap on a line strobe. A post-reset init sweep clears both banks so no undefined pixels are ever displayed.

Parameters:
- ADDR_W, 9, address width; each bank is 2^ADDR_W entries.
- LINE_LEN, 320, usable entries per bank, LINE_LEN <= 2^ADDR_W.
- PIX_W, 4, colour index width.
- PAL_W, 8, palette number width.
- CLEAR_VAL, all ones (PAL_W+PIX_W bits), backdrop value written on clear and init.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SWAP  in  1  line strobe; toggles bank roles.
- WR_LOAD  in  1  load write pointer from WR_ADDR_LOAD.
- WR_ADDR_LOAD  in  ADDR_W  start X for the next sprite strip.
- WR_DIR  in  1  0 = pointer increments, 1 = decrements (h-flip).
- WR_PAL_CE  in  1  latch WR_PAL.
- WR_PAL  in  PAL_W  sprite palette number.
- WR_CE  in  1  pixel strobe.
- WR_COLOR  in  PIX_W  pixel colour index; 0 = transparent.
- RD_START  in  1  reset read pointer to 0.
- RD_CE  in  1  read-and-clear strobe.
- RD_DATA  out  PAL_W+PIX_W  pixel {pal, colour}.
- RD_VALID  out  1  RD_DATA updated this cycle.
- BANK  out  1  index of the current write bank; the read bank is ~BANK.
- BUSY  out  1  init sweep in progress.

Behaviour:
- Reset values: BANK=0, BUSY=1, RD_DATA=CLEAR_VAL, RD_VALID=0, write pointer=0, read pointer=0, palette register=0, FSM=INIT, init counter=0.
- FSM states are INIT and RUN.
  - INIT: each cycle write CLEAR_VAL to address init_cnt in both banks, then init_cnt++.
  - After the write at LINE_LEN-1, go to RUN the next cycle.
  - INIT lasts exactly LINE_LEN cycles, and BUSY is high for those cycles.
  - All WR_*, RD_*, SWAP inputs are ignored in INIT.
- RESET asserted in any state (including mid-INIT) returns to INIT with init_cnt=0, and the sweep restarts.
- Palette register: on WR_PAL_CE, pal <= WR_PAL. A pixel written in the same cycle uses the old pal.
- Write side, RUN state:
  - WR_LOAD has priority: w_ptr <= WR_ADDR_LOAD. No RAM write occurs, even if WR_CE is high.
  - Else on WR_CE: if WR_COLOR != 0 and w_ptr < LINE_LEN, write {pal, WR_COLOR} to bank[BANK][w_ptr].
  - In either case w_ptr <= w_ptr ± 1 (by WR_DIR), modulo 2^ADDR_W. Transparent pixels and out-of-range positions still advance the pointer.
- Read side, RUN state:
  - RD_START has priority: r_ptr <= 0, with no read.
  - Else on RD_CE with r_ptr < LINE_LEN:
    - RD_DATA <= bank[~BANK][r_ptr] on the next edge, so latency is 1 cycle.
    - Same cycle: bank[~BANK][r_ptr] <= CLEAR_VAL (read-before-write).
    - r_ptr++.
  - On RD_CE with r_ptr >= LINE_LEN: RD_DATA <= CLEAR_VAL, no clear write, and r_ptr holds (saturates).
  - RD_VALID is RD_CE registered; it is 0 on RD_START cycles and in INIT.
- SWAP in RUN: BANK <= ~BANK and r_ptr <= 0; w_ptr is unchanged.
  - Any write or read in the same cycle as SWAP uses the pre-swap bank.
  - SWAP with RD_START is the same as SWAP alone.
- Each bank has one read port and one write port. The write-port source is muxed: the write bank takes pixel writes, the read bank takes clear writes. The two never collide.
- A pixel write to the read bank is impossible by construction.

Test Plan:
- Reset, then hold RD_CE during and after BUSY → BUSY high exactly 320 cycles. The first 320 reads after BUSY falls return 0xFFF; RD_VALID stays 0 during INIT.
- Pal=0x12; WR_LOAD with addr 10, WR_DIR=0; 4 pixels with colours 3,0,5,7; then SWAP, RD_START, read addresses 10..13 → 0x123, 0xFFF, 0x125, 0x127. A second pass over the same bank (SWAP twice) returns 0xFFF at all four addresses.
- WR_LOAD addr 319, WR_DIR=0, colours 1,2 → address 319 = {pal,1}. The second pixel targets address 320 and is dropped. Read saturates at r_ptr=320 returning 0xFFF with RD_VALID=1.
- WR_DIR=1, load 5, colours 1,2,3 → addresses 5,4,3 hold colours 1,2,3. Load 1, three pixels → the pointer wraps 1,0,511; address 511 is not written.
- WR_LOAD and WR_CE together with colour 9 → no write; the pointer equals the load value on the next cycle. WR_PAL_CE with a pixel in the same cycle → the pixel carries the old palette.
- Assert RESET at init_cnt=100 mid-INIT → BUSY stays high for a full 320 cycles after release; BANK=0.
